// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue/decode controller feeding a registered 32-bit ALU
module alu_issue_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        aluop_sel,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] operand_1,
    output logic [DATA_W-1:0] operand_2,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              res_branch_taken,
    output logic              res_illegal
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_GT  = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    localparam logic [DATA_W-1:0] SIGN_BIT = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        CAPT = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t            state;
    logic              is_beq;
    logic [3:0]        dec_op;
    logic [DATA_W-1:0] dec_a;
    logic [DATA_W-1:0] dec_b;
    logic              dec_illegal;

    // Set-less-than is built from the ALU's unsigned greater-than with swapped
    // operands; the signed form flips both sign bits to bias into unsigned order.
    always_comb begin
        dec_op      = OP_ADD;
        dec_a       = rs_val;
        dec_b       = rt_val;
        dec_illegal = 1'b0;
        case (aluop_sel)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                case (funct)
                    6'b100000, 6'b100001: dec_op = OP_ADD;
                    6'b100010, 6'b100011: dec_op = OP_SUB;
                    6'b100100:            dec_op = OP_AND;
                    6'b100101:            dec_op = OP_OR;
                    6'b100111:            dec_op = OP_NOR;
                    6'b101011: begin
                        dec_op = OP_GT;
                        dec_a  = rt_val;
                        dec_b  = rs_val;
                    end
                    6'b101010: begin
                        dec_op = OP_GT;
                        dec_a  = rt_val ^ SIGN_BIT;
                        dec_b  = rs_val ^ SIGN_BIT;
                    end
                    default:              dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            in_ready         <= 1'b1;
            res_valid        <= 1'b0;
            res_data         <= '0;
            res_zero         <= 1'b0;
            res_branch_taken <= 1'b0;
            res_illegal      <= 1'b0;
            alu_op           <= 4'b0000;
            operand_1        <= '0;
            operand_2        <= '0;
            is_beq           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (dec_illegal) begin
                            state            <= DONE;
                            res_valid        <= 1'b1;
                            res_illegal      <= 1'b1;
                            res_data         <= '0;
                            res_zero         <= 1'b0;
                            res_branch_taken <= 1'b0;
                        end else begin
                            state     <= EXEC;
                            alu_op    <= dec_op;
                            operand_1 <= dec_a;
                            operand_2 <= dec_b;
                            is_beq    <= (aluop_sel == 2'b01);
                        end
                    end
                end
                EXEC: state <= CAPT;
                CAPT: begin
                    state            <= DONE;
                    res_valid        <= 1'b1;
                    res_data         <= alu_out;
                    res_zero         <= alu_zero;
                    res_branch_taken <= is_beq & alu_zero;
                    res_illegal      <= 1'b0;
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - randomized self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  aluop_sel = 2'b00;
    logic [5:0]  funct = 6'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic [3:0]  alu_op;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_zero;
    logic        res_branch_taken;
    logic        res_illegal;

    int tests_run = 0;
    int tests_failed = 0;

    logic [3:0]  last_op = 4'd0;
    logic [31:0] last_o1 = 32'd0;
    logic [31:0] last_o2 = 32'd0;

    alu_issue_ctrl #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .aluop_sel(aluop_sel), .funct(funct), .rs_val(rs_val), .rt_val(rt_val),
        .alu_op(alu_op), .operand_1(operand_1), .operand_2(operand_2),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_zero(res_zero), .res_branch_taken(res_branch_taken), .res_illegal(res_illegal)
    );

    always #5 clk = ~clk;

    // ALU with a one-cycle registered result
    always @(posedge clk) begin
        case (alu_op)
            4'b0000: alu_out <= operand_1 & operand_2;
            4'b0001: alu_out <= operand_1 | operand_2;
            4'b0010: alu_out <= operand_1 + operand_2;
            4'b0110: alu_out <= operand_1 - operand_2;
            4'b0111: alu_out <= (operand_1 > operand_2) ? 32'd1 : 32'd0;
            4'b1100: alu_out <= ~(operand_1 | operand_2);
            default: alu_out <= 32'hDEAD_BEEF;
        endcase
    end
    assign alu_zero = (alu_out == 32'd0);

    // Reference: instruction semantics straight from the MIPS meaning of each op
    function automatic void ref_op(input logic [1:0] sel, input logic [5:0] f,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [3:0] op, output logic [31:0] o1,
                                   output logic [31:0] o2, output logic ill,
                                   output logic [31:0] data, output logic br);
        ill = 1'b0; op = last_op; o1 = a; o2 = b; data = 32'd0;
        if (sel == 2'b00) begin op = 4'b0010; data = a + b; end
        else if (sel == 2'b01) begin op = 4'b0110; data = a - b; end
        else if (sel == 2'b10 && (f == 6'h20 || f == 6'h21)) begin op = 4'b0010; data = a + b; end
        else if (sel == 2'b10 && (f == 6'h22 || f == 6'h23)) begin op = 4'b0110; data = a - b; end
        else if (sel == 2'b10 && f == 6'h24) begin op = 4'b0000; data = a & b; end
        else if (sel == 2'b10 && f == 6'h25) begin op = 4'b0001; data = a | b; end
        else if (sel == 2'b10 && f == 6'h27) begin op = 4'b1100; data = ~(a | b); end
        else if (sel == 2'b10 && f == 6'h2B) begin
            op = 4'b0111; o1 = b; o2 = a; data = (a < b) ? 32'd1 : 32'd0;
        end else if (sel == 2'b10 && f == 6'h2A) begin
            op = 4'b0111; o1 = {~b[31], b[30:0]}; o2 = {~a[31], a[30:0]};
            data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        end else begin
            ill = 1'b1; op = last_op; o1 = last_o1; o2 = last_o2;
        end
        br = (sel == 2'b01) && !ill && (data == 32'd0);
    endfunction

    task automatic send(input logic [1:0] sel, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b, output bit ok);
        bit rdy;
        aluop_sel = sel; funct = f; rs_val = a; rt_val = b; in_valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) begin ok = 1'b1; break; end
        end
        in_valid = 1'b0;
        aluop_sel = 2'($urandom); funct = 6'($urandom); rs_val = $urandom; rt_val = $urandom;
    endtask

    task automatic run_op(input logic [1:0] sel, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b, input int hold,
                          output logic [3:0] g_op, output logic [31:0] g_o1,
                          output logic [31:0] g_o2, output int g_lat,
                          output logic [31:0] g_data, output logic g_zero,
                          output logic g_br, output logic g_ill, output bit g_stable);
        bit ok;
        send(sel, f, a, b, ok);
        g_op = alu_op; g_o1 = operand_1; g_o2 = operand_2;
        g_lat = 0;
        while (!res_valid && g_lat < 20) begin @(posedge clk); #1; g_lat++; end
        if (!ok || !res_valid) g_lat = -1;
        g_data = res_data; g_zero = res_zero; g_br = res_branch_taken; g_ill = res_illegal;
        g_stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!res_valid || in_ready || res_data !== g_data || res_zero !== g_zero ||
                res_branch_taken !== g_br || res_illegal !== g_ill) g_stable = 1'b0;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        tests_run++; if ({res_data, res_zero, res_branch_taken, res_illegal} !== 35'd0) begin
            tests_failed++; $display("FAIL reset_res_fields got=%h/%b%b%b exp=0", res_data, res_zero, res_branch_taken, res_illegal); end
        tests_run++; if ({alu_op, operand_1, operand_2} !== 68'd0) begin
            tests_failed++; $display("FAIL reset_alu_inputs got=%h/%h/%h exp=0", alu_op, operand_1, operand_2); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_exec;
        bit ok;
        int stray;
        send(2'b10, 6'h20, 32'h11, 32'h22, ok);
        rst_n = 1'b0;
        #1;
        tests_run++; if (res_valid !== 1'b0 || alu_op !== 4'b0000) begin
            tests_failed++; $display("FAIL midreset_async got valid=%b op=%b exp 0/0000", res_valid, alu_op); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_op = 4'd0; last_o1 = 32'd0; last_o2 = 32'd0;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL midreset_in_ready got=%b exp=1", in_ready); end
        stray = 0;
        repeat (6) begin @(posedge clk); #1; if (res_valid) stray++; end
        tests_run++; if (stray != 0) begin tests_failed++; $display("FAIL midreset_stray got=%0d exp=0", stray); end
    endtask

    task automatic test_add;
        logic [3:0] op; logic [31:0] o1, o2, d; int lat; logic z, br, ill; bit st;
        run_op(2'b10, 6'h20, 32'hFFFF_FFFF, 32'h2, 0, op, o1, o2, lat, d, z, br, ill, st);
        tests_run++; if (op !== 4'b0010) begin tests_failed++; $display("FAIL add_op got=%b exp=0010", op); end
        tests_run++; if (d !== 32'h1 || z !== 1'b0) begin tests_failed++; $display("FAIL add_data got=%h z=%b exp=00000001 z=0", d, z); end
        tests_run++; if (lat != 2) begin tests_failed++; $display("FAIL add_latency got=%0d exp=2", lat); end
        last_op = op; last_o1 = o1; last_o2 = o2;
    endtask

    task automatic test_beq;
        logic [3:0] op; logic [31:0] o1, o2, d; int lat; logic z, br, ill; bit st;
        run_op(2'b01, 6'h00, 32'h1234, 32'h1234, 0, op, o1, o2, lat, d, z, br, ill, st);
        tests_run++; if (op !== 4'b0110) begin tests_failed++; $display("FAIL beq_op got=%b exp=0110", op); end
        tests_run++; if (z !== 1'b1 || br !== 1'b1) begin tests_failed++; $display("FAIL beq_taken got z=%b br=%b exp 1/1", z, br); end
        run_op(2'b01, 6'h00, 32'h1234, 32'h1235, 0, op, o1, o2, lat, d, z, br, ill, st);
        tests_run++; if (br !== 1'b0 || z !== 1'b0 || d !== 32'hFFFF_FFFF) begin
            tests_failed++; $display("FAIL beq_not_taken got br=%b z=%b d=%h exp 0/0/ffffffff", br, z, d); end
        last_op = op; last_o1 = o1; last_o2 = o2;
    endtask

    task automatic test_slt;
        logic [3:0] op; logic [31:0] o1, o2, d; int lat; logic z, br, ill; bit st;
        run_op(2'b10, 6'h2A, 32'hFFFF_FFFF, 32'h1, 0, op, o1, o2, lat, d, z, br, ill, st);
        tests_run++; if (d !== 32'h1) begin tests_failed++; $display("FAIL slt_data got=%h exp=1", d); end
        tests_run++; if (o1 !== 32'h8000_0001 || o2 !== 32'h7FFF_FFFF) begin
            tests_failed++; $display("FAIL slt_operands got=%h/%h exp=80000001/7fffffff", o1, o2); end
        run_op(2'b10, 6'h2B, 32'hFFFF_FFFF, 32'h1, 0, op, o1, o2, lat, d, z, br, ill, st);
        tests_run++; if (d !== 32'h0 || op !== 4'b0111) begin tests_failed++; $display("FAIL sltu_data got=%h op=%b exp=0 op=0111", d, op); end
        last_op = op; last_o1 = o1; last_o2 = o2;
    endtask

    task automatic test_illegal;
        logic [3:0] op; logic [31:0] o1, o2, d; int lat; logic z, br, ill; bit st;
        run_op(2'b10, 6'b011000, 32'h5, 32'h6, 0, op, o1, o2, lat, d, z, br, ill, st);
        tests_run++; if (ill !== 1'b1 || d !== 32'h0 || z !== 1'b0) begin
            tests_failed++; $display("FAIL illegal_funct got ill=%b d=%h z=%b exp 1/0/0", ill, d, z); end
        tests_run++; if (lat != 0) begin tests_failed++; $display("FAIL illegal_latency got=%0d exp=0", lat); end
        tests_run++; if (op !== last_op || o1 !== last_o1 || o2 !== last_o2) begin
            tests_failed++; $display("FAIL illegal_hold got=%b/%h/%h exp=%b/%h/%h", op, o1, o2, last_op, last_o1, last_o2); end
        run_op(2'b11, 6'h20, 32'h5, 32'h6, 0, op, o1, o2, lat, d, z, br, ill, st);
        tests_run++; if (ill !== 1'b1 || br !== 1'b0) begin tests_failed++; $display("FAIL illegal_sel11 got ill=%b br=%b exp 1/0", ill, br); end
    endtask

    task automatic test_backpressure;
        logic [3:0] op; logic [31:0] o1, o2, d; int lat; logic z, br, ill; bit st, ok, bad;
        logic [31:0] held;
        send(2'b10, 6'h27, 32'h0F0F_0000, 32'h0000_00F0, ok);
        lat = 0;
        while (!res_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        held = res_data;
        tests_run++; if (held !== 32'hF0F0_FF0F) begin tests_failed++; $display("FAIL bp_nor_data got=%h exp=f0f0ff0f", held); end
        aluop_sel = 2'b00; rs_val = 32'd100; rt_val = 32'd23; in_valid = 1'b1;
        bad = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (!res_valid || in_ready || res_data !== held) bad = 1'b1;
        end
        tests_run++; if (bad) begin tests_failed++; $display("FAIL bp_stall got unstable data=%h ready=%b exp held f0f0ff0f, in_ready=0", res_data, in_ready); end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        tests_run++; if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
            tests_failed++; $display("FAIL bp_release got in_ready=%b res_valid=%b exp 1/0", in_ready, res_valid); end
        run_op(2'b00, 6'h00, 32'd100, 32'd23, 0, op, o1, o2, lat, d, z, br, ill, st);
        tests_run++; if (d !== 32'd123 || lat != 2) begin tests_failed++; $display("FAIL bp_second got d=%h lat=%0d exp=7b lat=2", d, lat); end
        last_op = op; last_o1 = o1; last_o2 = o2;
    endtask

    task automatic test_back_to_back;
        bit rdy;
        int first, second, c;
        logic [1:0] sels [2];
        int exp_gap [2];
        sels[0] = 2'b00; exp_gap[0] = 4;
        sels[1] = 2'b11; exp_gap[1] = 2;
        for (int k = 0; k < 2; k++) begin
            aluop_sel = sels[k]; funct = 6'h0; rs_val = 32'd7; rt_val = 32'd9;
            res_ready = 1'b1; in_valid = 1'b1; first = -1; second = -1;
            for (c = 0; c < 16; c++) begin
                rdy = in_ready;
                @(posedge clk); #1;
                if (rdy) begin
                    if (first < 0) first = c;
                    else if (second < 0) second = c;
                end
            end
            in_valid = 1'b0;
            for (c = 0; c < 10 && !in_ready; c++) begin @(posedge clk); #1; end
            res_ready = 1'b0;
            tests_run++; if (second < 0 || second - first != exp_gap[k]) begin
                tests_failed++; $display("FAIL b2b_interval sel=%b got=%0d exp=%0d", sels[k], second - first, exp_gap[k]); end
        end
        last_op = 4'b0010; last_o1 = 32'd7; last_o2 = 32'd9;
    endtask

    task automatic test_random;
        logic [3:0] op, e_op; logic [31:0] o1, o2, d, e_o1, e_o2, e_d, a, b;
        int lat, hold; logic z, br, ill, e_ill, e_br; bit st;
        logic [5:0] f;
        logic [1:0] sel;
        logic [5:0] functs [10];
        functs = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B, 6'h26};
        for (int n = 0; n < 40; n++) begin
            sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) sel = 2'b10;
            f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : functs[$urandom_range(0, 9)];
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? a : $urandom;
            if ($urandom_range(0, 4) == 0) a = {1'b1, 31'($urandom)};
            hold = $urandom_range(0, 3);
            ref_op(sel, f, a, b, e_op, e_o1, e_o2, e_ill, e_d, e_br);
            run_op(sel, f, a, b, hold, op, o1, o2, lat, d, z, br, ill, st);
            tests_run++; if (op !== e_op || o1 !== e_o1 || o2 !== e_o2) begin
                tests_failed++; $display("FAIL rnd_alu_in sel=%b f=%h got=%b/%h/%h exp=%b/%h/%h", sel, f, op, o1, o2, e_op, e_o1, e_o2); end
            tests_run++; if (ill !== e_ill || d !== e_d) begin
                tests_failed++; $display("FAIL rnd_result sel=%b f=%h a=%h b=%h got=%h ill=%b exp=%h ill=%b", sel, f, a, b, d, ill, e_d, e_ill); end
            tests_run++; if (z !== (!e_ill && e_d == 32'd0) || br !== e_br) begin
                tests_failed++; $display("FAIL rnd_flags sel=%b got z=%b br=%b exp z=%b br=%b", sel, z, br, !e_ill && e_d == 32'd0, e_br); end
            tests_run++; if (lat != (e_ill ? 0 : 2) || !st) begin
                tests_failed++; $display("FAIL rnd_timing got lat=%0d stable=%b exp lat=%0d stable=1", lat, st, e_ill ? 0 : 2); end
            if (!e_ill) begin last_op = e_op; last_o1 = e_o1; last_o2 = e_o2; end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_beq();
        test_slt();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_exec();
        test_add();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue and decode controller that drives the 32-bit ALU from the datapath side. It accepts one operation per handshake and decodes MIPS ALUOp/funct into the ALU's 4-bit `alu_op` encoding. It presents registered operands, waits out the ALU's one-cycle registered result latency, and returns an aligned result, zero flag, branch decision and illegal-op flag on a valid/ready handshake.

## Interface
Parameters:
- `DATA_W`, 32, operand/result width (only 32 is supported).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock, shared with the ALU
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  request valid
- `in_ready`  out  1  controller can accept a request
- `aluop_sel`  in  2  00=ADD (lw/sw), 01=SUB (beq), 10=R-type funct decode, 11=illegal
- `funct`  in  6  R-type function field, used only when `aluop_sel`=10
- `rs_val`, `rt_val`  in  32 each  source operands
- `alu_op`  out  4  to ALU
- `operand_1`, `operand_2`  out  32 each  to ALU
- `alu_out`  in  32  from ALU (registered inside ALU)
- `alu_zero`  in  1  from ALU, true when `alu_out`==0
- `res_valid`  out  1  result valid
- `res_ready`  in  1  consumer accepts result
- `res_data`  out  32  captured ALU result
- `res_zero`  out  1  captured zero flag
- `res_branch_taken`  out  1  1 only for `aluop_sel`=01 with zero result
- `res_illegal`  out  1  unsupported operation

## Operation
ALU encoding driven on `alu_op`: AND=0000, OR=0001, ADD=0010, SUB=0110, GT=0111 (unsigned `operand_1`>`operand_2`), NOR=1100.

Decode for `aluop_sel`=10, by `funct`:
- 100000/100001 -> ADD
- 100010/100011 -> SUB
- 100100 -> AND
- 100101 -> OR
- 100111 -> NOR
- 101011 (SLTU) -> GT with `operand_1`=`rt_val`, `operand_2`=`rs_val`.
- 101010 (SLT) -> GT with operands swapped as for SLTU and bit 31 of both inverted (signed-to-unsigned bias).
- Any other funct, or `aluop_sel`=11, is illegal.

For all other ops, `operand_1`=`rs_val` and `operand_2`=`rt_val`. Arithmetic wraps modulo 2^32; there is no overflow flag.

States:
- IDLE: `in_ready`=1. On `in_valid`, register `alu_op`/operands and go to EXEC. If the op is illegal, go straight to DONE with `res_illegal`=1, `res_data`=0, `res_zero`=0, `res_branch_taken`=0, and leave `alu_op`/operands unchanged.
- EXEC: hold ALU inputs; the ALU samples them at the end of this cycle. Go to CAPT.
- CAPT: capture `alu_out` into `res_data` and `alu_zero` into `res_zero`. Set `res_branch_taken` = (`aluop_sel`==01) & `alu_zero`. Go to DONE.
- DONE: `res_valid`=1; all `res_*` held stable. On `res_ready`, go to IDLE.

Other rules:
- `alu_op`/operands stay held from accept until the next accept.
- `in_ready`=0 outside IDLE. No request is dropped or reordered.
- The request fields (`aluop_sel` etc.) are latched at accept, so later changes on the inputs do not affect the result.

## Timing
- Reset (async assert): state=IDLE. Outputs: `in_ready`=1, `res_valid`=0, `res_data`=0, `res_zero`=0, `res_branch_taken`=0, `res_illegal`=0, `alu_op`=0000, `operand_1`=`operand_2`=0.
- Reset is released synchronously to `clk`.
- Legal op accepted at edge k:
  - ALU inputs valid after edge k.
  - ALU result valid after edge k+1.
  - Captured at edge k+2.
  - `res_valid`=1 after edge k+2 (3-cycle latency).
- Illegal op accepted at edge k: `res_valid`=1 after edge k (1-cycle latency).
- DONE with `res_ready` already high leaves after one cycle. The next accept is possible at the edge after the return to IDLE.
- Minimum issue interval is 4 cycles for legal ops and 2 for illegal ops.
- `res_ready` high outside DONE is ignored.
- Reset mid-operation (any state): the in-flight op is discarded and `res_valid` drops immediately. No result is produced after reset release.

## Test plan
- Reset: assert `rst_n`=0 mid-EXEC -> `res_valid`=0 and `alu_op`=0000 immediately. After release, `in_ready`=1 and no stray result appears.
- R-type ADD: `funct`=100000, rs=0xFFFFFFFF, rt=0x2 -> `alu_op`=0010; `res_data`=0x00000001, `res_zero`=0, `res_valid` 3 cycles after accept.
- BEQ: `aluop_sel`=01, rs=rt=0x1234 -> `alu_op`=0110, `res_zero`=1, `res_branch_taken`=1. With rt=0x1235 -> `res_branch_taken`=0.
- SLT vs SLTU, rs=0xFFFFFFFF, rt=0x1:
  - SLT -> `res_data`=1; operands on the ALU are 0x80000001 / 0x7FFFFFFF.
  - SLTU -> `res_data`=0.
- Illegal: `funct`=011000 -> `res_illegal`=1, `res_data`=0, `res_valid` 1 cycle after accept; `alu_op` unchanged.
- Backpressure: hold `res_ready`=0 for 5 cycles after a NOR of 0x0F0F0000/0x000000F0 -> `res_data`=0xF0F0FF0F held stable, `in_ready`=0 throughout. A second request issued while stalled is accepted only after `res_ready`.
